// File: rtl/asmi_readback.sv
// ============================================================================
// asmi_readback : streams EPCS16 flash pages from the ASMI read port into the
//                 Tx FIFO (bit-reversed to PC order), one handshake per page.
// Optional feature macro: READBACK_CHECKSUM_EN (adds 16-bit byte-sum output).
// Revision: 1.0
// ============================================================================
`default_nettype none

module asmi_readback #(
  parameter logic [23:0] BASE_ADDR  = 24'h100000,
  parameter int          PAGE_BYTES = 256,
  parameter int          FIFO_DEPTH = 1024,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_req,
  output logic        read_ACK,
  input  logic [13:0] num_blocks,
  input  logic [9:0]  IF_Tx_used,
  output logic        wrreq,
  output logic [7:0]  IF_PHY_data,
  output logic        block_ready,
  input  logic        block_ready_ACK,
  output logic        read_done,
  input  logic        read_done_ACK,
  output logic        read_error,
  output logic [23:0] asmi_addr,
  output logic        asmi_rden,
  output logic        asmi_read,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_data_valid,
  input  logic        asmi_busy
`ifdef READBACK_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [10:0] SPACE_LIMIT = 11'(FIFO_DEPTH - PAGE_BYTES);
  localparam logic [8:0]  LAST_BYTE   = 9'(PAGE_BYTES - 1);
  localparam logic [23:0] ADDR_STEP   = 24'(PAGE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_START      = 3'd2,
    S_STREAM     = 3'd3,
    S_NOTIFY     = 3'd4,
    S_WAIT_ACK   = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] nblocks_q, nblocks_d;
  logic [13:0] page_q, page_d;
  logic [8:0]  byte_count_q, byte_count_d;
  logic [15:0] timer_q, timer_d;
  logic        read_ack_d, wrreq_d, block_ready_d, read_done_d, read_error_d;
  logic        rden_d, asmi_read_d;
  logic [7:0]  data_d;
  logic [23:0] addr_d;
  logic [7:0]  rev_byte;
`ifdef READBACK_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  assign checksum = checksum_q;
`endif

  // ASMI delivers bytes LSB-first; the PC expects MSB-first.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign rev_byte = bitrev8(asmi_dataout);

  always_comb begin
    state_d      = state_q;
    nblocks_d    = nblocks_q;
    page_d       = page_q;
    byte_count_d = byte_count_q;
    timer_d      = timer_q;
    read_ack_d   = read_ACK;
    wrreq_d      = 1'b0;
    data_d       = IF_PHY_data;
    block_ready_d = block_ready;
    read_done_d  = read_done;
    read_error_d = read_error;
    addr_d       = asmi_addr;
    rden_d       = asmi_rden;
    asmi_read_d  = 1'b0;
`ifdef READBACK_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    if (!read_req) read_ack_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        block_ready_d = 1'b0;
        read_done_d   = 1'b0;
        if (read_req) begin
          read_ack_d   = 1'b1;
          nblocks_d    = num_blocks;
          page_d       = 14'd0;
          read_error_d = 1'b0;
          addr_d       = BASE_ADDR;
`ifdef READBACK_CHECKSUM_EN
          checksum_d   = 16'd0;
`endif
          if (num_blocks == 14'd0) begin
            state_d     = S_DONE;
            read_done_d = 1'b1;
          end else begin
            state_d = S_WAIT_SPACE;
          end
        end
      end

      S_WAIT_SPACE: begin
        if (!asmi_busy && ({1'b0, IF_Tx_used} <= SPACE_LIMIT)) state_d = S_START;
      end

      S_START: begin
        rden_d       = 1'b1;
        asmi_read_d  = 1'b1;
        byte_count_d = 9'd0;
        timer_d      = 16'd0;
        state_d      = S_STREAM;
      end

      S_STREAM: begin
        if (asmi_data_valid) begin
          wrreq_d      = 1'b1;
          data_d       = rev_byte;
          byte_count_d = byte_count_q + 9'd1;
          timer_d      = 16'd0;
`ifdef READBACK_CHECKSUM_EN
          checksum_d   = checksum_q + {8'd0, rev_byte};
`endif
          if (byte_count_q == LAST_BYTE) begin
            rden_d  = 1'b0;
            page_d  = page_q + 14'd1;
            state_d = S_NOTIFY;
          end
        end else if (timer_q == TIMEOUT) begin
          rden_d       = 1'b0;
          read_error_d = 1'b1;
          read_done_d  = 1'b1;
          state_d      = S_DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_NOTIFY: begin
        block_ready_d = 1'b1;
        state_d       = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (block_ready_ACK) begin
          block_ready_d = 1'b0;
          if (page_q == nblocks_q) begin
            read_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            addr_d  = asmi_addr + ADDR_STEP;
            state_d = S_WAIT_SPACE;
          end
        end
      end

      S_DONE: begin
        read_done_d = 1'b1;
        if (read_done_ACK) begin
          read_done_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nblocks_q    <= 14'd0;
      page_q       <= 14'd0;
      byte_count_q <= 9'd0;
      timer_q      <= 16'd0;
      read_ACK     <= 1'b0;
      wrreq        <= 1'b0;
      IF_PHY_data  <= 8'd0;
      block_ready  <= 1'b0;
      read_done    <= 1'b0;
      read_error   <= 1'b0;
      asmi_addr    <= BASE_ADDR;
      asmi_rden    <= 1'b0;
      asmi_read    <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      checksum_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      nblocks_q    <= nblocks_d;
      page_q       <= page_d;
      byte_count_q <= byte_count_d;
      timer_q      <= timer_d;
      read_ACK     <= read_ack_d;
      wrreq        <= wrreq_d;
      IF_PHY_data  <= data_d;
      block_ready  <= block_ready_d;
      read_done    <= read_done_d;
      read_error   <= read_error_d;
      asmi_addr    <= addr_d;
      asmi_rden    <= rden_d;
      asmi_read    <= asmi_read_d;
`ifdef READBACK_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_asmi_readback.sv
// ============================================================================
// tb_asmi_readback : directed scoreboard bench for asmi_readback with a
//                    behavioural ASMI flash model (A[i] = i[7:0]).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_asmi_readback;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read_req = 1'b0;
  logic        read_ACK;
  logic [13:0] num_blocks = 14'd0;
  logic [9:0]  IF_Tx_used = 10'd0;
  logic        wrreq;
  logic [7:0]  IF_PHY_data;
  logic        block_ready;
  logic        block_ready_ACK = 1'b0;
  logic        read_done;
  logic        read_done_ACK = 1'b0;
  logic        read_error;
  logic [23:0] asmi_addr;
  logic        asmi_rden;
  logic        asmi_read;
  logic [7:0]  asmi_dataout = 8'd0;
  logic        asmi_data_valid = 1'b0;
  logic        asmi_busy = 1'b0;
`ifdef READBACK_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  asmi_readback dut (
    .clock(clock), .reset(reset), .read_req(read_req), .read_ACK(read_ACK),
    .num_blocks(num_blocks), .IF_Tx_used(IF_Tx_used), .wrreq(wrreq),
    .IF_PHY_data(IF_PHY_data), .block_ready(block_ready),
    .block_ready_ACK(block_ready_ACK), .read_done(read_done),
    .read_done_ACK(read_done_ACK), .read_error(read_error),
    .asmi_addr(asmi_addr), .asmi_rden(asmi_rden), .asmi_read(asmi_read),
    .asmi_dataout(asmi_dataout), .asmi_data_valid(asmi_data_valid),
    .asmi_busy(asmi_busy)
`ifdef READBACK_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  // flash model state and scoreboard queues
  logic [7:0]  exp_q[$];
  logic [23:0] addr_q[$];
  int          reads_seen = 0;
  int          wr_seen = 0;
  int          mod_cnt = 0;
  int          mod_delay = 0;
  int          stall_at = -1;
  int          last_valid_cyc = 0;
  bit          mod_active = 0;
  bit          gap_done = 0;
  bit          use_const = 0;
  bit          prev_read = 0;
  logic [7:0]  const_byte = 8'h00;
  logic [23:0] mod_base = 24'd0;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ASMI model: two-clock latency after the read pulse, a one-clock gap every 9 bytes
  always @(negedge clock) begin
    logic [7:0] b;
    asmi_data_valid = 1'b0;
    if (asmi_read) begin
      mod_active = 1; mod_base = asmi_addr; mod_cnt = 0; mod_delay = 2; gap_done = 0;
      reads_seen++;
      addr_q.push_back(asmi_addr);
    end else if (!asmi_rden) begin
      mod_active = 0;
    end else if (mod_active && mod_cnt < 256) begin
      if (mod_delay > 0) mod_delay--;
      else if (stall_at >= 0 && mod_cnt >= stall_at) begin end
      else if (mod_cnt % 9 == 4 && !gap_done) gap_done = 1;
      else begin
        gap_done = 0;
        b = use_const ? const_byte : (mod_base[7:0] + 8'(mod_cnt));
        asmi_dataout = b;
        asmi_data_valid = 1'b1;
        exp_q.push_back(rev8(b));
        mod_cnt++;
        last_valid_cyc = cyc;
      end
    end
  end

  // monitor: pops the scoreboard on every FIFO write
  always @(negedge clock) begin
    if (wrreq) begin
      wr_seen++;
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_data", {24'd0, IF_PHY_data}, {24'd0, exp_q.pop_front()});
    end
    if (asmi_read) check("read_pulse_1clk", {31'd0, prev_read}, 32'd0);
    prev_read = asmi_read;
  end

  task automatic clear_counts();
    reads_seen = 0; wr_seen = 0; addr_q.delete();
  endtask

  task automatic request(input logic [13:0] nb);
    int n = 0;
    num_blocks = nb;
    read_req = 1'b1;
    while (!read_ACK && n < 10) begin @(negedge clock); n++; end
    check("read_ACK", {31'd0, read_ACK}, 32'd1);
    check("read_error_cleared", {31'd0, read_error}, 32'd0);
    read_req = 1'b0;
    @(negedge clock);
    check("read_ACK_drop", {31'd0, read_ACK}, 32'd0);
  endtask

  task automatic serve(output int pages);
    int n = 0;
    bit done = 0;
    pages = 0;
    while (n < 20000 && !done) begin
      @(negedge clock); n++;
      if (read_done) done = 1;
      else if (block_ready) begin
        pages++;
        block_ready_ACK = 1'b1;
        @(negedge clock);
        block_ready_ACK = 1'b0;
        @(negedge clock);
        check("block_ready_drop", {31'd0, block_ready}, 32'd0);
      end
    end
    check("read_done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_done();
    read_done_ACK = 1'b1;
    @(negedge clock);
    read_done_ACK = 1'b0;
    check("read_done_drop", {31'd0, read_done}, 32'd0);
  endtask

  initial begin
    int pages;
    int n;
    repeat (3) @(negedge clock);
    check("rst_flags", {26'd0, read_ACK, wrreq, block_ready, read_done, read_error, asmi_read}, 32'd0);
    check("rst_rden", {31'd0, asmi_rden}, 32'd0);
    check("rst_addr", {8'd0, asmi_addr}, 32'h100000);
    check("rst_data", {24'd0, IF_PHY_data}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: two pages of A[i]=i
    clear_counts();
    request(14'd2);
    serve(pages);
    check("t1_pages", pages, 2);
    check("t1_wr", wr_seen, 512);
    check("t1_reads", reads_seen, 2);
    check("t1_addr_n", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check("t1_addr0", {8'd0, addr_q[0]}, 32'h100000);
      check("t1_addr1", {8'd0, addr_q[1]}, 32'h100100);
    end
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_no_err", {31'd0, read_error}, 32'd0);
    check("t1_rden_low", {31'd0, asmi_rden}, 32'd0);
    finish_done();

    // 2: Tx FIFO too full holds off the page start
    clear_counts();
    IF_Tx_used = 10'd800;
    request(14'd1);
    repeat (40) @(negedge clock);
    check("t2_hold_800", reads_seen, 0);
    IF_Tx_used = 10'd769;
    repeat (10) @(negedge clock);
    check("t2_hold_769", reads_seen, 0);
    IF_Tx_used = 10'd768;
    serve(pages);
    check("t2_pages", pages, 1);
    check("t2_reads", reads_seen, 1);
    check("t2_wr", wr_seen, 256);
    if (addr_q.size() == 1) check("t2_addr0", {8'd0, addr_q[0]}, 32'h100000);
    finish_done();
    IF_Tx_used = 10'd0;

    // 3: zero pages
    clear_counts();
    request(14'd0);
    serve(pages);
    check("t3_pages", pages, 0);
    check("t3_reads", reads_seen, 0);
    check("t3_wr", wr_seen, 0);
    finish_done();

    // 4: flash stalls after 100 bytes -> timeout abort
    clear_counts();
    stall_at = 100;
    request(14'd1);
    serve(pages);
    n = cyc - last_valid_cyc;
    check("t4_wr", wr_seen, 100);
    check("t4_err", {31'd0, read_error}, 32'd1);
    check("t4_rden_low", {31'd0, asmi_rden}, 32'd0);
    check("t4_timeout_window", {31'd0, (n >= 4097 && n <= 4099)}, 32'd1);
    finish_done();
    check("t4_err_held", {31'd0, read_error}, 32'd1);
    stall_at = -1;
    exp_q.delete();

    // 5: reset in the middle of the second page
    clear_counts();
    request(14'd2);
    n = 0;
    while (!(reads_seen == 2 && mod_cnt >= 50) && n < 3000) begin
      @(negedge clock); n++;
      block_ready_ACK = (block_ready && !block_ready_ACK);
    end
    check("t5_trigger", {31'd0, (reads_seen == 2 && mod_cnt >= 50)}, 32'd1);
    block_ready_ACK = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_flags", {26'd0, read_ACK, wrreq, block_ready, read_done, read_error, asmi_read}, 32'd0);
    check("t5_rst_rden", {31'd0, asmi_rden}, 32'd0);
    check("t5_rst_addr", {8'd0, asmi_addr}, 32'h100000);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    clear_counts();
    request(14'd1);
    serve(pages);
    check("t5_pages", pages, 1);
    check("t5_wr", wr_seen, 256);
    if (addr_q.size() == 1) check("t5_addr0", {8'd0, addr_q[0]}, 32'h100000);
    finish_done();

`ifdef READBACK_CHECKSUM_EN
    // 6: 256 bytes of 8'h01 -> 256 * 8'h80
    clear_counts();
    use_const = 1; const_byte = 8'h01;
    request(14'd1);
    serve(pages);
    check("t6_wr", wr_seen, 256);
    check("t6_checksum", {16'd0, checksum}, 32'h8000);
    finish_done();
    use_const = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
